// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC: FSM state encoding, overflow-mode
// constants and the accumulator width rule.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Worst-case sum of n full-precision dw x dw signed products.
   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/mac_dot_param_sat_narrow.sv
// Narrows the full-precision accumulator to a DW-bit signed result, flagging
// out-of-range values and either wrapping or clamping them.
module sat_narrow
   import mac_pkg::*;
#(
   parameter int AW = 19,
   parameter int DW = 8
) (
   input  logic signed [AW-1:0] acc,
   input  logic                 mode,
   output logic signed [DW-1:0] result,
   output logic                 overflow
);

   localparam logic signed [AW-1:0] POS_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] NEG_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   always_comb begin
      overflow = (acc > POS_MAX) || (acc < NEG_MIN);
      result   = acc[DW-1:0];
      if ((mode == MODE_SAT) && overflow) begin
         result = acc[AW-1] ? NEG_MIN[DW-1:0] : POS_MAX[DW-1:0];
      end
   end

endmodule

// File: rtl/mac_dot_param.sv
// Sequential signed dot product: one shared multiplier walks the N element
// pairs, then the sum is narrowed (wrap or saturate) and presented with done.
module mac_dot_param
   import mac_pkg::*;
#(
   parameter int DW = 8,
   parameter int N  = 5,
   parameter int AW = acc_width(DW, N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [N*DW-1:0]      in_a,
   input  logic [N*DW-1:0]      in_b,
   output logic                 busy,
   output logic                 done,
   output logic signed [DW-1:0] result,
   output logic                 overflow
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * DW;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t               state_q, state_d;
   logic [N*DW-1:0]      a_q, a_d;
   logic [N*DW-1:0]      b_q, b_d;
   logic                 mode_q, mode_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 done_q, done_d;
   logic signed [DW-1:0] result_q, result_d;
   logic                 overflow_q, overflow_d;
   logic                 capture;

   logic signed [DW-1:0] a_elem [N];
   logic signed [DW-1:0] b_elem [N];
   logic signed [DW-1:0] mul_a, mul_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_ext;
   logic signed [DW-1:0] narrow_result;
   logic                 narrow_overflow;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign a_elem[gi] = a_q[gi*DW +: DW];
         assign b_elem[gi] = b_q[gi*DW +: DW];
      end
   endgenerate

   // The single multiplier is steered by the element index.
   assign mul_a    = a_elem[idx_q];
   assign mul_b    = b_elem[idx_q];
   assign prod     = PW'(mul_a) * PW'(mul_b);
   assign prod_ext = AW'(prod);

   sat_narrow #(
      .AW (AW),
      .DW (DW)
   ) u_sat_narrow (
      .acc      (acc_q),
      .mode     (mode_q),
      .result   (narrow_result),
      .overflow (narrow_overflow)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      done_d     = 1'b0;
      result_d   = result_q;
      overflow_d = overflow_q;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q + prod_ext;
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = FIN;
            end
         end
         FIN: begin
            result_d   = narrow_result;
            overflow_d = narrow_overflow;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      mode_d = mode_q;
      if (capture) begin
         a_d    = in_a;
         b_d    = in_b;
         mode_d = mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         idx_q      <= '0;
         done_q     <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   // Operand snapshot has no reset; it is always reloaded before use.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign result   = result_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_mac_dot_param.sv
// Self-checking bench for mac_dot_param (DW=8, N=5): transaction-level model
// checked every cycle plus directed vectors with literal expectations.
module tb_mac_dot_param;

   localparam int DW = 8;
   localparam int N  = 5;
   localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (DW-1));

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 mode;
   logic [N*DW-1:0]      in_a;
   logic [N*DW-1:0]      in_b;
   logic                 busy;
   logic                 done;
   logic signed [DW-1:0] result;
   logic                 overflow;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mac_dot_param #(.DW(DW), .N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .in_a     (in_a),
      .in_b     (in_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
   );

   function automatic logic [N*DW-1:0] pack5(input int e0, input int e1, input int e2,
                                              input int e3, input int e4);
      logic [N*DW-1:0] v;
      v = {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
      return v;
   endfunction

   function automatic longint dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
      longint s;
      logic signed [DW-1:0] ea, eb;
      s = 0;
      for (int i = 0; i < N; i++) begin
         ea = a[i*DW +: DW];
         eb = b[i*DW +: DW];
         s  = s + longint'(ea) * longint'(eb);
      end
      return s;
   endfunction

   function automatic bit f_ovf(input longint s);
      return (s > MAXV) || (s < MINV);
   endfunction

   function automatic logic [DW-1:0] f_res(input longint s, input logic md);
      logic [63:0] u;
      if (md && s > MAXV)      u = 64'(MAXV);
      else if (md && s < MINV) u = 64'(MINV);
      else                     u = 64'(s);
      return u[DW-1:0];
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: an accepted start keeps the unit busy for N+1 cycles, then done.
   int              m_cnt = 0;
   logic            m_done = 1'b0;
   logic [DW-1:0]   m_res = '0;
   logic            m_ovf = 1'b0;
   logic [DW-1:0]   p_res = '0;
   logic            p_ovf = 1'b0;

   always @(posedge clk) begin
      m_done <= 1'b0;
      if (rst) begin
         m_cnt <= 0;
         m_res <= '0;
         m_ovf <= 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt <= N + 1;
            p_res <= f_res(dot(in_a, in_b), mode);
            p_ovf <= f_ovf(dot(in_a, in_b));
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_res  <= p_res;
            m_ovf  <= p_ovf;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", longint'(busy), longint'(m_cnt != 0));
         check("cyc_done", longint'(done), longint'(m_done));
         check("cyc_result", longint'($unsigned(result)), longint'(m_res));
         check("cyc_overflow", longint'(overflow), longint'(m_ovf));
      end
   end

   task automatic run_op(input string nm, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                         input logic md, input longint exp_res, input bit exp_ovf);
      int j, bcnt;
      bit got;
      @(negedge clk);
      in_a = a; in_b = b; mode = md; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_a = ~a; in_b = a; mode = ~md;
      j = 0; bcnt = 0; got = 1'b0;
      while (j < 20 && !got) begin
         if (done) got = 1'b1;
         else begin
            bcnt += int'(busy);
            j++;
            @(negedge clk);
         end
      end
      check({nm, "_seen"}, longint'(got), 1);
      if (got) begin
         check({nm, "_latency"}, j, N + 1);
         check({nm, "_busycyc"}, bcnt, N + 1);
         check({nm, "_result"}, longint'(result), exp_res);
         check({nm, "_ovf"}, longint'(overflow), longint'(exp_ovf));
         $display("op %s: result=%0d overflow=%0d latency=%0d", nm, result, overflow, j);
      end
   endtask

   initial begin
      int ndone, last_j, j;
      logic [N*DW-1:0] ones, m127, mm128, h100, one_hot, e12345;

      ones    = pack5(1, 1, 1, 1, 1);
      m127    = pack5(127, 127, 127, 127, 127);
      mm128   = pack5(-128, -128, -128, -128, -128);
      h100    = pack5(100, 100, 100, 100, 100);
      one_hot = pack5(1, 0, 0, 0, 0);
      e12345  = pack5(1, 2, 3, 4, 5);

      rst = 1'b1; start = 1'b0; mode = 1'b0; in_a = '0; in_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_result", longint'(result), 0);
      check("rst_ovf", longint'(overflow), 0);
      rst = 1'b0;

      run_op("ones", e12345, ones, 1'b0, 15, 1'b0);
      run_op("max_sat", m127, m127, 1'b1, 127, 1'b1);
      run_op("max_wrap", m127, m127, 1'b0, 5, 1'b1);
      run_op("min_sat", mm128, m127, 1'b1, -128, 1'b1);
      run_op("excursion", pack5(100, 100, -100, -100, 0), h100, 1'b0, 0, 1'b0);
      run_op("edge_pos", pack5(127, 0, 0, 0, 0), one_hot, 1'b1, 127, 1'b0);
      run_op("edge_neg", pack5(-128, 0, 0, 0, 0), one_hot, 1'b1, -128, 1'b0);
      run_op("wrap150", pack5(50, 0, 0, 0, 0), pack5(3, 3, 3, 3, 3), 1'b0, -106, 1'b1);

      // start pulsed while busy must be ignored
      @(negedge clk);
      in_a = e12345; in_b = pack5(2, 2, 2, 2, 2); mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; in_a = m127; in_b = m127;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("ignore_start_dones", ndone, 1);
      check("ignore_start_result", longint'(result), 30);
      $display("op ignore_start: dones=%0d result=%0d", ndone, result);

      // reset in mid-run aborts without a done pulse
      @(negedge clk);
      in_a = m127; in_b = m127; mode = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", longint'(busy), 0);
      check("abort_result", longint'(result), 0);
      check("abort_ovf", longint'(overflow), 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_dones", ndone, 0);
      $display("op abort: dones=%0d result=%0d busy=%0d", ndone, result, busy);

      // start held high: one result every N+2 cycles
      @(negedge clk);
      in_a = e12345; in_b = pack5(-3, -3, -3, -3, -3); mode = 1'b0; start = 1'b1;
      ndone = 0; last_j = -1;
      for (j = 0; j < 35; j++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (last_j < 0) check("stream_first", j, N + 1);
            else            check("stream_gap", j - last_j, N + 2);
            check("stream_result", longint'(result), -45);
            last_j = j;
            $display("op stream: done at %0d result=%0d", j, result);
         end
      end
      start = 1'b0;
      check("stream_dones", ndone, 5);
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mac_dot_param.md
MAC_DOT_PARAM -- requirements
Module: mac_dot_param

Interface
REQ-001 Parameter DW, default 8, signed element width (4..16).
REQ-002 Parameter N, default 5, elements per dot product (2..16).
REQ-003 Parameter AW, default 2*DW+$clog2(N), internal accumulator width; SHALL NOT be overridden below this value.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a new dot product; sampled only when busy=0.
REQ-007 mode  input  1  0 = wrap (truncate), 1 = saturate; sampled with start.
REQ-008 in_a  input  N*DW  row vector; element i at bits [DW*i+DW-1 : DW*i], two's complement.
REQ-009 in_b  input  N*DW  column vector, same packing as in_a.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking result/overflow valid.
REQ-012 result  output  DW  signed dot product, narrowed per mode.
REQ-013 overflow  output  1  final sum outside signed DW range.

Function
REQ-014 FSM states IDLE, RUN, FIN; busy=1 in RUN and FIN, 0 in IDLE.
REQ-015 IDLE: start=1 at edge k SHALL capture in_a, in_b, mode into internal registers, clear accumulator and element index, enter RUN.
REQ-016 Operands SHALL be captured; in_a/in_b/mode changes after edge k SHALL NOT affect the operation.
REQ-017 RUN: edge k+1+i (i=0..N-1) adds full-precision product a[i]*b[i] (2*DW bits, sign-extended to AW) to accumulator; element 0 first.
REQ-018 After element N-1, FSM enters FIN; FIN lasts exactly one cycle.
REQ-019 FIN (edge k+N+1): register result and overflow, set done=1, return to IDLE; latency start-to-done = N+1 edges.
REQ-020 Accumulator SHALL never overflow internally; intermediate products/sums exceeding DW bits SHALL NOT set overflow.
REQ-021 overflow=1 iff final accumulator > 2^(DW-1)-1 or < -2^(DW-1).
REQ-022 mode=0: result = accumulator[DW-1:0]; mode=1: result clamps to 2^(DW-1)-1 or -2^(DW-1) on overflow, else exact value.
REQ-023 result and overflow SHALL hold their values from done until next FIN.
REQ-024 done SHALL be high exactly one cycle per completed operation; start while busy=1 SHALL be ignored (no queuing).
REQ-025 start sampled in the cycle done=1 (FSM in IDLE) SHALL be accepted, giving back-to-back throughput of one result per N+2 cycles.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, result=0, overflow=0, accumulator=0, index=0 at the next edge.
REQ-027 rst SHALL take priority over start and over any in-flight operation; an aborted operation SHALL NOT produce done.
REQ-028 Captured operand registers need not be cleared by rst.

Structure
REQ-029 Shared package mac_pkg SHALL hold state encoding (IDLE/RUN/FIN), mode constants MODE_WRAP=0/MODE_SAT=1, and accumulator-width function.
REQ-030 One combinational sub-module sat_narrow (params AW, DW; in acc, mode; out result, overflow) SHALL implement REQ-021/022.
REQ-031 Exactly one multiplier instance, time-multiplexed via element index; no per-element multiplier array.

Verification (DW=8, N=5)
REQ-032 a=[1,2,3,4,5], b=[1,1,1,1,1], mode=0 -> result=15, overflow=0, done exactly 6 edges after start edge, busy high 6 cycles.
REQ-033 a=b=all 127: mode=1 -> result=127, overflow=1; mode=0 -> result=5 (80645 mod 256), overflow=1.
REQ-034 a=all -128, b=all 127, mode=1 -> result=-128 (0x80), overflow=1.
REQ-035 a=[100,100,-100,-100,0], b=all 100 -> result=0, overflow=0 (intermediate excursions ignored).
REQ-036 start pulsed at RUN edge 2 -> ignored, single done; rst at RUN edge 3 -> next cycle busy=0, result=0, no done pulse.
REQ-037 start held high continuously with constant operands -> done every 7 cycles, identical results, no lost or duplicate done.
